// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequencer/arbiter for the byte-serial register file.
// Grants one whole-word read (rs1/rs2) or write-back (rd) at a time and walks
// the four byte phases LSB first, assembling read bytes into 32-bit words.
// Optional build macro: RF_RR_ARB_EN selects round-robin arbitration
// (default build: fixed write-over-read priority).
module regfile_access_ctrl #(
  parameter int REG_AW  = 4,
  parameter int XLEN    = 32,
  parameter int PHASE_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_req_valid,
  output logic               rd_req_ready,
  input  logic [REG_AW-1:0]  rd_req_rs1,
  input  logic [REG_AW-1:0]  rd_req_rs2,
  output logic               rd_rsp_valid,
  output logic [XLEN-1:0]    rd_rsp_rs1,
  output logic [XLEN-1:0]    rd_rsp_rs2,
  input  logic               wb_req_valid,
  output logic               wb_req_ready,
  input  logic [REG_AW-1:0]  wb_req_rd,
  input  logic [XLEN-1:0]    wb_req_data,
  output logic [PHASE_W-1:0] rf_phase,
  output logic [REG_AW-1:0]  rf_rs1,
  output logic [REG_AW-1:0]  rf_rs2,
  output logic [REG_AW-1:0]  rf_rd,
  output logic               rf_we,
  output logic [7:0]         rf_wdata,
  input  logic [7:0]         rf_rs1_dat,
  input  logic [7:0]         rf_rs2_dat,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [REG_AW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [XLEN-9:0]    hold1_q, hold1_d, hold2_q, hold2_d;
  logic [XLEN-1:0]    rsp1_q, rsp1_d, rsp2_q, rsp2_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]    asm1, asm2;
  logic [PHASE_W+2:0] byte_lsb;
  logic               idle, last_phase, prefer_wr, wb_grant, rd_grant;

  assign idle       = (state_q == IDLE);
  assign last_phase = &phase_q;
  assign byte_lsb   = {phase_q, 3'b000};

`ifdef RF_RR_ARB_EN
  logic last_wr_q, last_wr_d;
  // Whoever was not granted last wins a tie; reset value means "read last".
  assign prefer_wr = ~last_wr_q;
`else
  assign prefer_wr = 1'b1;
`endif

  // Arbitration: only the winner sees ready, and only in IDLE out of reset.
  always_comb begin
    wb_grant = rst_n && idle && wb_req_valid && (!rd_req_valid || prefer_wr);
    rd_grant = rst_n && idle && rd_req_valid && (!wb_req_valid || !prefer_wr);
  end

  assign wb_req_ready = wb_grant;
  assign rd_req_ready = rd_grant;

  // Merge the current phase's byte into the partially assembled words.
  always_comb begin
    asm1 = {8'h00, hold1_q};
    asm2 = {8'h00, hold2_q};
    asm1[byte_lsb +: 8] = rf_rs1_dat;
    asm2[byte_lsb +: 8] = rf_rs2_dat;
  end

  // Next-state: accept in IDLE, then four phases, response on the last read phase.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    hold1_d     = hold1_q;
    hold2_d     = hold2_q;
    rsp1_d      = rsp1_q;
    rsp2_d      = rsp2_q;
    rsp_valid_d = 1'b0;
`ifdef RF_RR_ARB_EN
    last_wr_d   = last_wr_q;
`endif
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (wb_grant) begin
          state_d = WRITE;
          rd_d    = wb_req_rd;
          wdata_d = wb_req_data;
`ifdef RF_RR_ARB_EN
          last_wr_d = 1'b1;
`endif
        end else if (rd_grant) begin
          state_d = READ;
          rs1_d   = rd_req_rs1;
          rs2_d   = rd_req_rs2;
`ifdef RF_RR_ARB_EN
          last_wr_d = 1'b0;
`endif
        end
      end
      READ: begin
        phase_d = phase_q + 1'b1;
        hold1_d = asm1[XLEN-9:0];
        hold2_d = asm2[XLEN-9:0];
        if (last_phase) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp1_d      = (rs1_q == '0) ? '0 : asm1;
          rsp2_d      = (rs2_q == '0) ? '0 : asm2;
        end
      end
      WRITE: begin
        phase_d = phase_q + 1'b1;
        if (last_phase) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
      rsp1_q      <= '0;
      rsp2_q      <= '0;
      rsp_valid_q <= 1'b0;
`ifdef RF_RR_ARB_EN
      last_wr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      hold1_q     <= hold1_d;
      hold2_q     <= hold2_d;
      rsp1_q      <= rsp1_d;
      rsp2_q      <= rsp2_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef RF_RR_ARB_EN
      last_wr_q   <= last_wr_d;
`endif
    end
  end

  // Register-file side: phase/data only meaningful while transferring.
  always_comb begin
    rf_phase = idle ? '0 : phase_q;
    rf_we    = (state_q == WRITE) && (rd_q != '0);
    rf_wdata = (state_q == WRITE) ? wdata_q[byte_lsb +: 8] : 8'h00;
  end

  assign rf_rs1       = rs1_q;
  assign rf_rs2       = rs2_q;
  assign rf_rd        = rd_q;
  assign busy         = !idle;
  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_rs1   = rsp1_q;
  assign rd_rsp_rs2   = rsp2_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a byte-serial register-file model.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [3:0]  rd_req_rs1 = '0, rd_req_rs2 = '0;
  logic        rd_rsp_valid;
  logic [31:0] rd_rsp_rs1, rd_rsp_rs2;
  logic        wb_req_valid = 1'b0, wb_req_ready;
  logic [3:0]  wb_req_rd = '0;
  logic [31:0] wb_req_data = '0;
  logic [1:0]  rf_phase;
  logic [3:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_we;
  logic [7:0]  rf_wdata, rf_rs1_dat, rf_rs2_dat;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic preload = 1'b1;

  regfile_access_ctrl #(.REG_AW(4), .XLEN(32), .PHASE_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_rs1(rd_req_rs1), .rd_req_rs2(rd_req_rs2),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_rs1(rd_rsp_rs1), .rd_rsp_rs2(rd_rsp_rs2),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_rd(wb_req_rd), .wb_req_data(wb_req_data),
    .rf_phase(rf_phase), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rs1_dat(rf_rs1_dat), .rf_rs2_dat(rf_rs2_dat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-file model: x0 holds garbage so zero-forcing is observable.
  logic [31:0] mem [16];
  assign rf_rs1_dat = mem[rf_rs1][{rf_phase, 3'b000} +: 8];
  assign rf_rs2_dat = mem[rf_rs2][{rf_phase, 3'b000} +: 8];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (rf_we) begin
      mem[rf_rd][{rf_phase, 3'b000} +: 8] <= rf_wdata;
    end
  end

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] data;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_write(input logic [3:0] idx, input logic [31:0] data, input string tag);
    int n = 0;
    wb_req_valid = 1'b1; wb_req_rd = idx; wb_req_data = data;
    #0;
    while (!wb_req_ready && n < 20) begin step(); n++; end
    check({tag, " wb_ready"}, {31'd0, wb_req_ready}, 32'd1);
    step();
    wb_req_valid = 1'b0; wb_req_rd = ~idx; wb_req_data = ~data;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s p%0d phase", tag, p), {30'd0, rf_phase}, p);
      check($sformatf("%s p%0d we", tag, p), {31'd0, rf_we}, {31'd0, idx != 4'd0});
      check($sformatf("%s p%0d rd", tag, p), {28'd0, rf_rd}, {28'd0, idx});
      check($sformatf("%s p%0d wdata", tag, p), {24'd0, rf_wdata}, {24'd0, data[8*p +: 8]});
      check($sformatf("%s p%0d busy", tag, p), {31'd0, busy}, 32'd1);
      step();
    end
    check({tag, " done busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done we"}, {31'd0, rf_we}, 32'd0);
  endtask

  task automatic run_read(input logic [3:0] a, input logic [3:0] b, input string tag,
                          output logic [31:0] r1, output logic [31:0] r2);
    int n = 0;
    rd_req_valid = 1'b1; rd_req_rs1 = a; rd_req_rs2 = b;
    #0;
    while (!rd_req_ready && n < 20) begin step(); n++; end
    check({tag, " rd_ready"}, {31'd0, rd_req_ready}, 32'd1);
    step();
    rd_req_valid = 1'b0; rd_req_rs1 = ~a; rd_req_rs2 = ~b;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s p%0d phase", tag, p), {30'd0, rf_phase}, p);
      check($sformatf("%s p%0d rsp_valid", tag, p), {31'd0, rd_rsp_valid}, 32'd0);
      check($sformatf("%s p%0d ready", tag, p), {30'd0, rd_req_ready, wb_req_ready}, 32'd0);
      step();
    end
    check({tag, " rsp_valid"}, {31'd0, rd_rsp_valid}, 32'd1);
    check({tag, " done busy"}, {31'd0, busy}, 32'd0);
    r1 = rd_rsp_rs1;
    r2 = rd_rsp_rs2;
  endtask

  vec_t vecs[10];
  logic [31:0] r1, r2;
  bit exp_w[3];

  initial begin
    vecs[0] = '{1'b1, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 4'd5, 4'd0, 32'h0, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 4'd7, 4'd0, 32'hCAFEF00D, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 4'd7, 4'd5, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 4'd0, 4'd0, 32'h0, 32'h00000000, 32'h00000000};
    vecs[5] = '{1'b0, 4'd9, 4'd1, 32'h0, 32'hA5A50009, 32'hA5A50001};
    vecs[6] = '{1'b1, 4'd0, 4'd0, 32'hFFFFFFFF, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 4'd0, 4'd5, 32'h0, 32'h00000000, 32'hDEADBEEF};
    vecs[8] = '{1'b1, 4'd5, 4'd0, 32'h01020304, 32'h0, 32'h0};
    vecs[9] = '{1'b0, 4'd5, 4'd5, 32'h0, 32'h01020304, 32'h01020304};

    // Reset with noisy inputs.
    for (int c = 0; c < 2; c++) begin
      rd_req_valid = 1'b1; wb_req_valid = 1'b1;
      rd_req_rs1 = 4'($urandom); rd_req_rs2 = 4'($urandom);
      wb_req_rd = 4'($urandom); wb_req_data = $urandom;
      step();
      check($sformatf("reset%0d rf", c), {rf_phase, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wdata},
            32'd0);
      check($sformatf("reset%0d status", c),
            {busy, rd_rsp_valid, rd_req_ready, wb_req_ready}, 32'd0);
      check($sformatf("reset%0d rsp", c), rd_rsp_rs1 | rd_rsp_rs2, 32'd0);
    end
    rd_req_valid = 1'b0; wb_req_valid = 1'b0;
    preload = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        run_write(vecs[i].a, vecs[i].data, $sformatf("v%0d", i));
      end else begin
        run_read(vecs[i].a, vecs[i].b, $sformatf("v%0d", i), r1, r2);
        check($sformatf("v%0d rs1", i), r1, vecs[i].e1);
        check($sformatf("v%0d rs2", i), r2, vecs[i].e2);
        step();
        check($sformatf("v%0d pulse", i), {31'd0, rd_rsp_valid}, 32'd0);
        check($sformatf("v%0d hold", i), rd_rsp_rs1, vecs[i].e1);
      end
    end

    // Tie: write x3 and read x3 together; write wins, read sees new value.
    wb_req_valid = 1'b1; wb_req_rd = 4'd3; wb_req_data = 32'h12345678;
    rd_req_valid = 1'b1; rd_req_rs1 = 4'd3; rd_req_rs2 = 4'd0;
    #0;
    check("tie wb_ready", {31'd0, wb_req_ready}, 32'd1);
    check("tie rd_ready", {31'd0, rd_req_ready}, 32'd0);
    step();
    wb_req_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("tie wait%0d rd_ready", p), {31'd0, rd_req_ready}, 32'd0);
      step();
    end
    check("tie T+5 rd_ready", {31'd0, rd_req_ready}, 32'd1);
    run_read(4'd3, 4'd0, "tie rd", r1, r2);
    check("tie rs1", r1, 32'h12345678);
    check("tie rs2", r2, 32'h0);

    // Sustained ties: last grant was a read.
`ifdef RF_RR_ARB_EN
    exp_w = '{1'b1, 1'b0, 1'b1};
`else
    exp_w = '{1'b1, 1'b1, 1'b1};
`endif
    wb_req_valid = 1'b1; wb_req_rd = 4'd3; wb_req_data = 32'h12345678;
    rd_req_valid = 1'b1; rd_req_rs1 = 4'd3; rd_req_rs2 = 4'd0;
    #0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("arb%0d wb_ready", g), {31'd0, wb_req_ready}, {31'd0, exp_w[g]});
      check($sformatf("arb%0d rd_ready", g), {31'd0, rd_req_ready}, {31'd0, !exp_w[g]});
      for (int c = 0; c < 5; c++) step();
    end
    wb_req_valid = 1'b0; rd_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();

    // Reset during phase 2 of a read.
    rd_req_valid = 1'b1; rd_req_rs1 = 4'd9; rd_req_rs2 = 4'd5;
    #0;
    check("abort rd_ready", {31'd0, rd_req_ready}, 32'd1);
    step();
    rd_req_valid = 1'b0;
    step(); step();
    check("abort phase2", {30'd0, rf_phase}, 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort we", {31'd0, rf_we}, 32'd0);
    check("abort phase", {30'd0, rf_phase}, 32'd0);
    begin
      int pulses = 0;
      for (int c = 0; c < 4; c++) begin
        if (rd_rsp_valid) pulses++;
        step();
      end
      check("abort no pulse", pulses, 32'd0);
    end
    run_read(4'd9, 4'd5, "post", r1, r2);
    check("post rs1", r1, 32'hA5A50009);
    check("post rs2", r2, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Sequencer and arbiter for the byte-serial register file: 16 x 32-bit registers accessed one byte per cycle under a 2-bit phase. It accepts whole-word read requests (two sources, rs1/rs2) and write-back requests (one destination, rd). It grants one request at a time and drives the 4-phase byte transfer, LSB first. Read bytes are assembled into 32-bit responses. Sits between decode/execute/writeback logic and the register_file instance in the core top.

Parameters:
REG_AW, 4, register index width (16 registers, x0 hardwired zero)
XLEN, 32, word width; must equal 8 * 2^PHASE_W
PHASE_W, 2, byte-phase counter width (4 phases per word)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
rd_req_valid  input  1  read request pending
rd_req_ready  output  1  read request accepted this cycle (valid && ready)
rd_req_rs1  input  REG_AW  first source index
rd_req_rs2  input  REG_AW  second source index
rd_rsp_valid  output  1  one-cycle pulse, response words valid
rd_rsp_rs1  output  XLEN  assembled rs1 value
rd_rsp_rs2  output  XLEN  assembled rs2 value
wb_req_valid  input  1  write-back request pending
wb_req_ready  output  1  write-back accepted this cycle
wb_req_rd  input  REG_AW  destination index
wb_req_data  input  XLEN  write data
rf_phase  output  PHASE_W  byte phase to register file
rf_rs1  output  REG_AW  register-file rs1 index
rf_rs2  output  REG_AW  register-file rs2 index
rf_rd  output  REG_AW  register-file rd index
rf_we  output  1  byte write enable
rf_wdata  output  8  write byte for current phase
rf_rs1_dat  input  8  rs1 byte for current phase (combinational from register file)
rf_rs2_dat  input  8  rs2 byte for current phase
busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- Reset values: state IDLE; all rf_* outputs 0; busy 0; rd_rsp_valid 0; rd_rsp_rs1/rs2 0; both ready outputs 0 during reset.
- States: IDLE, READ, WRITE.
- IDLE: ready is combinational.
  - Only the arbitration winner sees ready=1.
  - Default arbitration is fixed priority, write over read. A read issued in the same cycle as a write to the same register therefore returns the new value.
- Accept at cycle T (valid && ready): latch indices and wb_req_data. The requester may change its inputs from T+1.
  - Enter READ or WRITE with phase counter 0.
- READ/WRITE: occupy cycles T+1..T+4. rf_phase = 0,1,2,3 on those cycles.
  - Counter increments each cycle and wraps 3->0 on the transition back to IDLE.
- READ:
  - Each phase, capture rf_rs1_dat/rf_rs2_dat into byte [8*phase+7:8*phase] of the holding registers.
  - Any latched index equal to 0 forces that word to 0, ignoring register-file data.
  - rd_rsp_valid pulses at T+5 with the complete words. Response words hold until the next read completes.
  - No backpressure on the response.
- WRITE:
  - rf_we=1 on T+1..T+4, with rf_wdata = latched data byte[phase] and rf_rd = latched index.
  - If rd == 0, the transaction still runs 4 cycles but rf_we stays 0.
- Return to IDLE at T+5. A new accept is possible at T+5, giving one transaction per 5 cycles.
- Ready is never asserted outside IDLE. Requests held valid while busy wait without loss.
- In IDLE: rf_we=0, rf_phase=0, rf_wdata=0. rf_rs1/rf_rs2/rf_rd hold their last latched values.
- Reset mid-transaction:
  - Abort; rf_we=0 from the next cycle.
  - No rd_rsp_valid pulse.
  - A partially written register is left as-is, which is acceptable.

Optional Feature:
RF_RR_ARB_EN: when defined, arbitration is round-robin.
- A last-grant flag is updated on each accept.
- On simultaneous requests, the requester not granted last wins.
- Reset value of the flag is "read last", so the first tie goes to write.
- Single-requester behaviour is unchanged.
- Undefined: fixed write-over-read priority.

Test Plan:
1. Hold rst_n=0 for 2 cycles with random inputs -> every output 0, busy 0, no ready.
2. Write-back rd=5, data 0xDEADBEEF at T -> rf_we=1 on T+1..T+4; rf_wdata EF,BE,AD,DE; rf_phase 0..3; rf_rd=5; busy 0 at T+5.
3. Read rs1=5, rs2=0, with a register-file model holding x5=0xDEADBEEF -> rd_rsp_valid at T+5 only; rs1=0xDEADBEEF; rs2=0x00000000.
4. Simultaneous write x3=0x12345678 and read rs1=3 -> write accepted first. Read accepted at T+5 and returns 0x12345678 at T+10. Under RF_RR_ARB_EN, repeated ties alternate grants.
5. Write-back rd=0, data 0xFFFFFFFF -> accepted; rf_we stays 0 for all 4 phases; a subsequent read of x0 returns 0.
6. Assert rst_n=0 during phase 2 of a read -> state IDLE and rf_we=0 next cycle; no rd_rsp_valid; a fresh read afterwards completes normally.
